pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the RISC datapath.

---
 rtl/pc_fetch_unit.sv | 123 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: req/ack fetch from imem, valid/ready toward decode.
// Optional FETCH_PERF_EN adds perf_fetches/perf_stalls counters.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            pc_src_sel
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetches,
    output logic [31:0]     perf_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            pend;
    logic [XLEN-1:0] pend_pc;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= word_align(RESET_PC);
            pend        <= 1'b0;
            pend_pc     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            pc_src_sel  <= 1'b0;
        end else begin
            pc_src_sel <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (redirect_valid) begin
                        pc         <= word_align(redirect_pc);
                        pc_src_sel <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (pend || redirect_valid) begin
                            // Response belongs to the abandoned path: drop it and refetch at the target
                            pc         <= redirect_valid ? word_align(redirect_pc) : pend_pc;
                            pend       <= 1'b0;
                            pc_src_sel <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc_inc(pc);
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Address must stay stable until ack, so the target waits here
                        pend    <= 1'b1;
                        pend_pc <= word_align(redirect_pc);
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= word_align(redirect_pc);
                        pc_src_sel  <= 1'b1;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches <= '0;
            perf_stalls  <= '0;
        end else begin
            if (instr_valid && instr_ready) begin
                perf_fetches <= perf_fetches + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: behavioural instruction memory with programmable wait states,
// scoreboard of delivered (pc, instr) pairs, plus a second instance with RESET_PC near the top.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pc_src_sel;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic        w_sel;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_stalls;
    logic [31:0] w_pf;
    logic [31:0] w_ps;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_cycles = 0;
    int   wcnt = 0;
    logic ack_force = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc_src_sel(pc_src_sel)
`ifdef FETCH_PERF_EN
        , .perf_fetches(perf_fetches), .perf_stalls(perf_stalls)
`endif
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_pc),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc), .pc_src_sel(w_sel)
`ifdef FETCH_PERF_EN
        , .perf_fetches(w_pf), .perf_stalls(w_ps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack after wait_cycles idle request cycles; ack_force injects a stray response
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end
    assign imem_ack   = (imem_req && (wcnt == wait_cycles)) || ack_force;
    assign imem_rdata = ack_force ? 32'hDEAD_BEEF : mem_word(imem_addr);

    assign w_ack      = w_req;
    assign w_rdata    = mem_word(w_addr);
    assign w_ready    = 1'b1;
    assign w_redir    = 1'b0;
    assign w_redir_pc = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int max);
        @(negedge clk);
        for (int i = 0; i < max && instr_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic accept_one();
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: delivered pc=%h instr=%h, expected no delivery", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e.pc || instr !== e.data) begin
                        errors++;
                        $display("FAIL sb_deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 instr_pc, instr, e.pc, e.data);
                    end
                end
            end
        end
    endtask

    task automatic start_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d undelivered entries, expected 0", exp_q.size());
        end
        exp_q.delete();
        tick();
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 6;
        if (imem_req !== 1'b0)     begin errors++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
        if (instr_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b, expected 0", instr_valid); end
        if (instr !== 32'h0)       begin errors++; $display("FAIL rst_instr: got %h, expected 0", instr); end
        if (instr_pc !== 32'h0)    begin errors++; $display("FAIL rst_instr_pc: got %h, expected 0", instr_pc); end
        if (pc_src_sel !== 1'b0)   begin errors++; $display("FAIL rst_sel: got %b, expected 0", pc_src_sel); end
        if (imem_addr !== 32'h0)   begin errors++; $display("FAIL rst_addr: got %h, expected 0", imem_addr); end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_fetches !== 32'h0 || perf_stalls !== 32'h0) begin
            errors++;
            $display("FAIL rst_perf: got fetches=%0d stalls=%0d, expected 0/0", perf_fetches, perf_stalls);
        end
`endif
    endtask

    task automatic test_zero_wait();
        int first = 0;
        int n_acks = 0;
        wait_cycles = 0;
        instr_ready = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        tick();
        rst_n = 1'b1;
        // Release cycle counts as cycle 1
        for (int n = 1; n <= 12 && n_acks < 3; n++) begin
            @(negedge clk);
            if (instr_valid === 1'b1 && first == 0) first = n;
            if (imem_req === 1'b1 && imem_ack === 1'b1) begin
                checks++;
                if (imem_addr !== 32'(n_acks * 4)) begin
                    errors++;
                    $display("FAIL seq_addr: got %h, expected %h", imem_addr, 32'(n_acks * 4));
                end
                n_acks++;
            end
        end
        tick();
        instr_ready = 1'b0;
        checks += 2;
        if (n_acks != 3) begin errors++; $display("FAIL seq_count: got %0d fetches, expected 3", n_acks); end
        if (first != 3)  begin errors++; $display("FAIL first_valid: got cycle %0d, expected 3", first); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'h8 || instr !== mem_word(32'h8)) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b req=%b pc=%h instr=%h, expected 1 0 %h %h",
                         instr_valid, imem_req, instr_pc, instr, 32'h8, mem_word(32'h8));
            end
        end
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
`ifdef FETCH_PERF_EN
        checks += 2;
        if (perf_stalls !== 32'd5)  begin errors++; $display("FAIL perf_stalls: got %0d, expected 5", perf_stalls); end
        if (perf_fetches !== 32'd2) begin errors++; $display("FAIL perf_fetches2: got %0d, expected 2", perf_fetches); end
`endif
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL stall_next: got req=%b addr=%h, expected 1 %h", imem_req, imem_addr, 32'hC);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_fetches !== 32'd3) begin errors++; $display("FAIL perf_fetches3: got %0d, expected 3", perf_fetches); end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b instr=%h pc=%h addr=%h req=%b, expected all 0",
                     instr_valid, instr, instr_pc, imem_addr, imem_req);
        end
        wait_cycles = 5;
        tick();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: got req=%b ack=%b, expected 1 0", imem_req, imem_ack);
        end
        tick();
        rst_n = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: got valid=%b req=%b, expected 0 0", instr_valid, imem_req);
        end
        tick();
        ack_force = 1'b0;
        wait_cycles = 0;
        push_exp(32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_restart: got valid=%b addr=%h, expected 0 0", instr_valid, imem_addr);
        end
        wait_valid(10);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL mid_refetch: got valid=%b pc=%h instr=%h, expected 1 0 %h",
                     instr_valid, instr_pc, instr, mem_word(32'h0));
        end
        accept_one();
    endtask

    task automatic test_ack_delay();
        start_reset();
        wait_cycles = 3;
        instr_ready = 1'b0;
        push_exp(32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || imem_ack !== (c == 4)) begin
                errors++;
                $display("FAIL delay_req: cycle %0d got req=%b addr=%h ack=%b, expected 1 0 %b",
                         c, imem_req, imem_addr, imem_ack, (c == 4));
            end
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== mem_word(32'h0) || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL delay_capture: got valid=%b instr=%h pc=%h, expected 1 %h 0",
                     instr_valid, instr, instr_pc, mem_word(32'h0));
        end
        accept_one();
    endtask

    task automatic test_redirect_pending();
        start_reset();
        wait_cycles = 3;
        instr_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (imem_addr !== 32'h0 || pc_src_sel !== 1'b0 || imem_ack !== (c == 5)) begin
                errors++;
                $display("FAIL redir_wait: cycle %0d got addr=%h sel=%b ack=%b, expected 0 0 %b",
                         c, imem_addr, pc_src_sel, imem_ack, (c == 5));
            end
        end
        push_exp(32'h100);
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h100 || pc_src_sel !== 1'b1 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_load: got addr=%h sel=%b req=%b valid=%b, expected 100 1 1 0",
                     imem_addr, pc_src_sel, imem_req, instr_valid);
        end
        @(negedge clk);
        checks++;
        if (pc_src_sel !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_pulse: got sel=%b addr=%h, expected 0 100", pc_src_sel, imem_addr);
        end
        wait_valid(10);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_fetch: got valid=%b pc=%h, expected 1 100", instr_valid, instr_pc);
        end
        accept_one();
    endtask

    task automatic test_hold_redirect();
        start_reset();
        wait_cycles = 0;
        instr_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_valid(10);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h2002;
        tick();
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        push_exp(32'h2000);
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h2000 || pc_src_sel !== 1'b1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL hold_redir: got valid=%b addr=%h sel=%b req=%b, expected 0 2000 1 1",
                     instr_valid, imem_addr, pc_src_sel, imem_req);
        end
        wait_valid(10);
        accept_one();
    endtask

    task automatic test_wrap();
        int n = 0;
        logic [31:0] a0 = 32'h1;
        logic [31:0] a1 = 32'h1;
        logic [31:0] p0 = 32'h1;
        start_reset();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12 && n < 2; c++) begin
            @(negedge clk);
            if (w_valid === 1'b1 && p0 === 32'h1) p0 = w_pc;
            if (w_req === 1'b1 && w_ack === 1'b1) begin
                if (n == 0) a0 = w_addr;
                else        a1 = w_addr;
                n++;
            end
        end
        checks += 3;
        if (a0 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h, expected FFFFFFFC", a0); end
        if (a1 !== 32'h0)         begin errors++; $display("FAIL wrap_second: got %h, expected 00000000", a1); end
        if (p0 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got %h, expected FFFFFFFC", p0); end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time exceeded, expected completion");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_zero_wait();
        test_stall();
        test_reset_mid_fetch();
        test_ack_delay();
        test_redirect_pending();
        test_hold_redirect();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_final: %0d undelivered entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
